// File: rtl/arm_pkg.sv
// Shared encodings for the ARM-subset pipeline: ALU commands, shift types, NZCV bit positions.
package arm_pkg;

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   localparam logic [1:0] SHIFT_LSL = 2'b00;
   localparam logic [1:0] SHIFT_LSR = 2'b01;
   localparam logic [1:0] SHIFT_ASR = 2'b10;
   localparam logic [1:0] SHIFT_ROR = 2'b11;

   // Bit positions inside the {N,Z,C,V} status word
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Signed overflow: operands agree in sign but the result does not
   function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/val2_generator.sv
// Second-operand generator: rotated immediate, memory offset, or shifted RM.
module val2_generator
   import arm_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rm_val,
   input  logic [11:0]      shift_operand,
   input  logic             imm,
   input  logic             mem_access,
   output logic [WIDTH-1:0] val2
);

   logic [WIDTH-1:0]   imm_ext;
   logic [WIDTH-1:0]   mem_offset;
   logic [WIDTH-1:0]   shifted;
   logic [2*WIDTH-1:0] imm_dbl;
   logic [2*WIDTH-1:0] rm_dbl;
   logic [4:0]         rot_amt;
   logic [4:0]         shift_amt;
   logic [1:0]         shift_type;

   assign rot_amt    = {shift_operand[11:8], 1'b0};
   assign shift_amt  = shift_operand[11:7];
   assign shift_type = shift_operand[6:5];
   assign imm_ext    = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
   assign mem_offset = {{(WIDTH-12){1'b0}}, shift_operand};

   // Rotates are done by shifting a doubled copy and keeping the low half
   assign imm_dbl = {imm_ext, imm_ext} >> rot_amt;
   assign rm_dbl  = {rm_val, rm_val} >> shift_amt;

   always_comb begin
      shifted = rm_val;
      case (shift_type)
         SHIFT_LSL: shifted = rm_val << shift_amt;
         SHIFT_LSR: shifted = rm_val >> shift_amt;
         SHIFT_ASR: shifted = $signed(rm_val) >>> shift_amt;
         default:   shifted = rm_dbl[WIDTH-1:0];
      endcase
   end

   always_comb begin
      if (imm)
         val2 = imm_dbl[WIDTH-1:0];
      else if (mem_access)
         val2 = mem_offset;
      else if (shift_amt == 5'd0)
         val2 = rm_val;
      else
         val2 = shifted;
   end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2, ALU, branch target, NZCV register and EX/MEM register.
// Define EXE_FORWARDING_EN to add operand-forwarding muxes in front of the ALU.
module exe_stage
   import arm_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              MEM_WB_EN,
   input  logic              MEM_R_EN,
   input  logic              MEM_W_EN,
   input  logic              B,
   input  logic              S,
   input  logic              Imm,
   input  logic [3:0]        EXE_CMD,
   input  logic [WIDTH-1:0]  PC,
   input  logic [WIDTH-1:0]  RNVal,
   input  logic [WIDTH-1:0]  RMVal,
   input  logic [11:0]       ShiftOperand,
   input  logic [23:0]       SignedImm24,
   input  logic [ADDR_W-1:0] Dest,
`ifdef EXE_FORWARDING_EN
   input  logic [1:0]        sel_src1,
   input  logic [1:0]        sel_src2,
   input  logic [WIDTH-1:0]  MEM_fwd,
   input  logic [WIDTH-1:0]  WB_fwd,
`endif
   output logic              BranchTaken,
   output logic [WIDTH-1:0]  BranchAddr,
   output logic [3:0]        Status,
   output logic              EM_WB_EN,
   output logic              EM_R_EN,
   output logic              EM_W_EN,
   output logic [WIDTH-1:0]  EM_ALURes,
   output logic [WIDTH-1:0]  EM_StoreVal,
   output logic [ADDR_W-1:0] EM_Dest
);

   logic [WIDTH-1:0] rn_op;
   logic [WIDTH-1:0] rm_op;
   logic [WIDTH-1:0] val2;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH:0]   sum;
   logic [3:0]       status_reg;
   logic [3:0]       flags_next;
   logic             cmd_valid;

`ifdef EXE_FORWARDING_EN
   always_comb begin
      case (sel_src1)
         2'b01:   rn_op = MEM_fwd;
         2'b10:   rn_op = WB_fwd;
         default: rn_op = RNVal;
      endcase
      case (sel_src2)
         2'b01:   rm_op = MEM_fwd;
         2'b10:   rm_op = WB_fwd;
         default: rm_op = RMVal;
      endcase
   end
`else
   assign rn_op = RNVal;
   assign rm_op = RMVal;
`endif

   val2_generator #(.WIDTH(WIDTH)) u_val2 (
      .rm_val        (rm_op),
      .shift_operand (ShiftOperand),
      .imm           (Imm),
      .mem_access    (MEM_R_EN | MEM_W_EN),
      .val2          (val2)
   );

   // Subtract forms add ~Val2 plus a carry-in, so C comes out as NOT borrow
   always_comb begin
      sum        = '0;
      alu_res    = '0;
      flags_next = status_reg;
      cmd_valid  = 1'b1;
      case (EXE_CMD)
         CMD_MOV: alu_res = val2;
         CMD_MVN: alu_res = ~val2;
         CMD_AND: alu_res = rn_op & val2;
         CMD_ORR: alu_res = rn_op | val2;
         CMD_EOR: alu_res = rn_op ^ val2;
         CMD_ADD, CMD_ADC: begin
            sum = {1'b0, rn_op} + {1'b0, val2}
                + {{WIDTH{1'b0}}, (EXE_CMD == CMD_ADC) ? status_reg[FLAG_C] : 1'b0};
            alu_res            = sum[WIDTH-1:0];
            flags_next[FLAG_C] = sum[WIDTH];
            flags_next[FLAG_V] = add_overflow(rn_op[WIDTH-1], val2[WIDTH-1], alu_res[WIDTH-1]);
         end
         CMD_SUB, CMD_SBC: begin
            sum = {1'b0, rn_op} + {1'b0, ~val2}
                + {{WIDTH{1'b0}}, (EXE_CMD == CMD_SBC) ? status_reg[FLAG_C] : 1'b1};
            alu_res            = sum[WIDTH-1:0];
            flags_next[FLAG_C] = sum[WIDTH];
            flags_next[FLAG_V] = add_overflow(rn_op[WIDTH-1], ~val2[WIDTH-1], alu_res[WIDTH-1]);
         end
         default: cmd_valid = 1'b0;
      endcase
      if (cmd_valid) begin
         flags_next[FLAG_N] = alu_res[WIDTH-1];
         flags_next[FLAG_Z] = (alu_res == '0);
      end
   end

   assign BranchTaken = B;
   assign BranchAddr  = PC + {{(WIDTH-26){SignedImm24[23]}}, SignedImm24, 2'b00};
   assign Status      = status_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         status_reg <= '0;
      else if (S && !freeze)
         status_reg <= flags_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         EM_WB_EN    <= 1'b0;
         EM_R_EN     <= 1'b0;
         EM_W_EN     <= 1'b0;
         EM_ALURes   <= '0;
         EM_StoreVal <= '0;
         EM_Dest     <= '0;
      end else if (!freeze) begin
         EM_WB_EN    <= MEM_WB_EN;
         EM_R_EN     <= MEM_R_EN;
         EM_W_EN     <= MEM_W_EN;
         EM_ALURes   <= alu_res;
         EM_StoreVal <= rm_op;
         EM_Dest     <= Dest;
      end
   end

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage: ALU, flags, Val2 modes, branch, freeze, async reset.
module tb_exe_stage;
   import arm_pkg::*;

   localparam int WIDTH  = 32;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              freeze = 1'b0;
   logic              MEM_WB_EN = 1'b0, MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
   logic              B = 1'b0, S = 1'b0, Imm = 1'b0;
   logic [3:0]        EXE_CMD = 4'd0;
   logic [WIDTH-1:0]  PC = '0, RNVal = '0, RMVal = '0;
   logic [11:0]       ShiftOperand = '0;
   logic [23:0]       SignedImm24 = '0;
   logic [ADDR_W-1:0] Dest = '0;
`ifdef EXE_FORWARDING_EN
   logic [1:0]        sel_src1 = 2'b00, sel_src2 = 2'b00;
   logic [WIDTH-1:0]  MEM_fwd = '0, WB_fwd = '0;
`endif
   logic              BranchTaken;
   logic [WIDTH-1:0]  BranchAddr;
   logic [3:0]        Status;
   logic              EM_WB_EN, EM_R_EN, EM_W_EN;
   logic [WIDTH-1:0]  EM_ALURes, EM_StoreVal;
   logic [ADDR_W-1:0] EM_Dest;

   int errors = 0;
   int checks = 0;

   exe_stage #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .freeze(freeze),
      .MEM_WB_EN(MEM_WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .B(B), .S(S), .Imm(Imm), .EXE_CMD(EXE_CMD),
      .PC(PC), .RNVal(RNVal), .RMVal(RMVal),
      .ShiftOperand(ShiftOperand), .SignedImm24(SignedImm24), .Dest(Dest),
`ifdef EXE_FORWARDING_EN
      .sel_src1(sel_src1), .sel_src2(sel_src2), .MEM_fwd(MEM_fwd), .WB_fwd(WB_fwd),
`endif
      .BranchTaken(BranchTaken), .BranchAddr(BranchAddr), .Status(Status),
      .EM_WB_EN(EM_WB_EN), .EM_R_EN(EM_R_EN), .EM_W_EN(EM_W_EN),
      .EM_ALURes(EM_ALURes), .EM_StoreVal(EM_StoreVal), .EM_Dest(EM_Dest)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [3:0] cmd, input logic s_i, input logic imm_i,
                        input logic r_i, input logic w_i, input logic [31:0] rn_i,
                        input logic [31:0] rm_i, input logic [11:0] so_i, input logic [3:0] d_i);
      EXE_CMD = cmd; S = s_i; Imm = imm_i; MEM_R_EN = r_i; MEM_W_EN = w_i;
      MEM_WB_EN = ~w_i; RNVal = rn_i; RMVal = rm_i; ShiftOperand = so_i; Dest = d_i;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      #2;
      checks++;
      if ({EM_WB_EN, EM_R_EN, EM_W_EN, EM_Dest} !== 7'd0) begin
         errors++; $display("FAIL reset_ctrl got=%h want=0", {EM_WB_EN, EM_R_EN, EM_W_EN, EM_Dest});
      end
      checks++;
      if (EM_ALURes !== 32'd0 || EM_StoreVal !== 32'd0) begin
         errors++; $display("FAIL reset_data res=%h store=%h want=0", EM_ALURes, EM_StoreVal);
      end
      checks++;
      if (Status !== 4'b0000) begin
         errors++; $display("FAIL reset_status got=%b want=0000", Status);
      end
      @(negedge clk) rst = 1'b1;
      $display("reset: status=%b res=%h", Status, EM_ALURes);
   endtask

   task automatic test_add_imm();
      drive(CMD_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 12'h003, 4'd1);
      tick();
      checks++;
      if (EM_ALURes !== 32'd8) begin errors++; $display("FAIL add_res got=%h want=8", EM_ALURes); end
      checks++;
      if (Status !== 4'b0000) begin errors++; $display("FAIL add_status got=%b want=0000", Status); end
      checks++;
      if (EM_Dest !== 4'd1 || EM_WB_EN !== 1'b1) begin
         errors++; $display("FAIL add_ctrl dest=%0d wb=%b want dest=1 wb=1", EM_Dest, EM_WB_EN);
      end
      $display("add: res=%h status=%b", EM_ALURes, Status);
   endtask

   task automatic test_sub_adc_sbc();
      drive(CMD_SUB, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'd3, 12'h000, 4'd2);
      tick();
      checks++;
      if (EM_ALURes !== 32'd0 || Status !== 4'b0110) begin
         errors++; $display("FAIL sub_zero res=%h status=%b want 0/0110", EM_ALURes, Status);
      end
      $display("sub: res=%h status=%b", EM_ALURes, Status);
      drive(CMD_ADC, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 12'h001, 4'd2);
      tick();
      checks++;
      if (EM_ALURes !== 32'd3) begin errors++; $display("FAIL adc_res got=%h want=3", EM_ALURes); end
      $display("adc: res=%h", EM_ALURes);
      drive(CMD_SUB, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'd0, 12'h005, 4'd2);
      tick();
      checks++;
      if (EM_ALURes !== 32'hFFFF_FFFE || Status !== 4'b1000) begin
         errors++; $display("FAIL sub_borrow res=%h status=%b want fffffffe/1000", EM_ALURes, Status);
      end
      $display("sub borrow: res=%h status=%b", EM_ALURes, Status);
      drive(CMD_SBC, 1'b0, 1'b1, 1'b0, 1'b0, 32'd10, 32'd0, 12'h003, 4'd2);
      tick();
      checks++;
      if (EM_ALURes !== 32'd6) begin errors++; $display("FAIL sbc_res got=%h want=6", EM_ALURes); end
      $display("sbc: res=%h", EM_ALURes);
   endtask

   task automatic test_overflow();
      drive(CMD_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd0, 12'h001, 4'd3);
      tick();
      checks++;
      if (EM_ALURes !== 32'h8000_0000 || Status !== 4'b1001) begin
         errors++; $display("FAIL ovf res=%h status=%b want 80000000/1001", EM_ALURes, Status);
      end
      drive(CMD_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 12'h001, 4'd3);
      tick();
      checks++;
      if (EM_ALURes !== 32'd2 || Status !== 4'b1001) begin
         errors++; $display("FAIL s0_hold res=%h status=%b want 2/1001", EM_ALURes, Status);
      end
      $display("overflow: res=%h status=%b", EM_ALURes, Status);
   endtask

   task automatic test_val2();
      logic [11:0] so_tab [6];
      logic [31:0] rm_tab [6];
      logic        imm_tab[6];
      logic [31:0] exp_tab[6];
      so_tab = '{12'h4FF, 12'h240, 12'h200, 12'h420, 12'h260, 12'h060};
      rm_tab = '{32'h0, 32'h8000_0000, 32'h0000_000F, 32'hF000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
      imm_tab = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_tab = '{32'hFF00_0000, 32'hF800_0000, 32'h0000_00F0, 32'h00F0_0000, 32'h8123_4567, 32'hDEAD_BEEF};
      for (int i = 0; i < 6; i++) begin
         drive(CMD_MOV, 1'b0, imm_tab[i], 1'b0, 1'b0, 32'd0, rm_tab[i], so_tab[i], 4'd4);
         tick();
         checks++;
         if (EM_ALURes !== exp_tab[i]) begin
            errors++; $display("FAIL val2_%0d so=%h got=%h want=%h", i, so_tab[i], EM_ALURes, exp_tab[i]);
         end
         $display("val2 so=%h rm=%h -> %h", so_tab[i], rm_tab[i], EM_ALURes);
      end
   endtask

   task automatic test_logic();
      logic [3:0]  cmd_tab[4];
      logic [31:0] exp_tab[4];
      cmd_tab = '{CMD_AND, CMD_ORR, CMD_EOR, CMD_MVN};
      exp_tab = '{32'h0000_F000, 32'h0000_FFF0, 32'h0000_0FF0, 32'hFFFF_00FF};
      for (int i = 0; i < 4; i++) begin
         drive(cmd_tab[i], 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 12'h000, 4'd5);
         tick();
         checks++;
         if (EM_ALURes !== exp_tab[i]) begin
            errors++; $display("FAIL logic_%0d got=%h want=%h", i, EM_ALURes, exp_tab[i]);
         end
         $display("logic cmd=%b -> %h", cmd_tab[i], EM_ALURes);
      end
      // MOV #0 with S: N,Z from result, C,V kept from 1001
      drive(CMD_MOV, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 12'h000, 4'd5);
      tick();
      checks++;
      if (Status !== 4'b0101) begin errors++; $display("FAIL mov_flags got=%b want=0101", Status); end
      drive(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'd7, 32'd0, 12'h009, 4'd5);
      tick();
      checks++;
      if (EM_ALURes !== 32'd0 || Status !== 4'b0101) begin
         errors++; $display("FAIL undef_cmd res=%h status=%b want 0/0101", EM_ALURes, Status);
      end
      $display("undef cmd: res=%h status=%b", EM_ALURes, Status);
   endtask

   task automatic test_store();
      drive(CMD_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 12'hFFF, 4'd6);
      tick();
      checks++;
      if (EM_ALURes !== 32'h0000_1FFF) begin errors++; $display("FAIL str_addr got=%h want=00001fff", EM_ALURes); end
      checks++;
      if (EM_StoreVal !== 32'hCAFE_F00D || EM_W_EN !== 1'b1 || EM_WB_EN !== 1'b0) begin
         errors++; $display("FAIL str_data store=%h w=%b wb=%b want cafef00d/1/0", EM_StoreVal, EM_W_EN, EM_WB_EN);
      end
      $display("str: addr=%h data=%h", EM_ALURes, EM_StoreVal);
   endtask

   task automatic test_branch();
      B = 1'b1; PC = 32'h100; SignedImm24 = 24'hFFFFFE;
      #1;
      checks++;
      if (BranchTaken !== 1'b1 || BranchAddr !== 32'h0000_00F8) begin
         errors++; $display("FAIL branch_back taken=%b addr=%h want 1/000000f8", BranchTaken, BranchAddr);
      end
      SignedImm24 = 24'h000010;
      #1;
      checks++;
      if (BranchAddr !== 32'h0000_0140) begin errors++; $display("FAIL branch_fwd got=%h want=00000140", BranchAddr); end
      B = 1'b0;
      #1;
      checks++;
      if (BranchTaken !== 1'b0) begin errors++; $display("FAIL branch_off got=%b want=0", BranchTaken); end
      $display("branch: addr=%h", BranchAddr);
   endtask

   task automatic test_freeze();
      drive(CMD_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 12'h001, 4'd7);
      tick();
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(CMD_SUB, 1'b1, 1'b1, 1'b0, 1'b0, 32'(i), 32'd0, 12'h005, 4'(i + 7));
         tick();
         checks++;
         if (EM_ALURes !== 32'd2 || Status !== 4'b0000 || EM_Dest !== 4'd7) begin
            errors++; $display("FAIL freeze_%0d res=%h status=%b dest=%0d want 2/0000/7", i, EM_ALURes, Status, EM_Dest);
         end
         $display("freeze cycle %0d: res=%h status=%b", i, EM_ALURes, Status);
      end
      freeze = 1'b0;
      tick();
      checks++;
      if (EM_ALURes !== 32'hFFFF_FFFD || Status !== 4'b1000 || EM_Dest !== 4'd9) begin
         errors++; $display("FAIL unfreeze res=%h status=%b dest=%0d want fffffffd/1000/9", EM_ALURes, Status, EM_Dest);
      end
      $display("unfreeze: res=%h status=%b", EM_ALURes, Status);
   endtask

   task automatic test_async_reset();
      freeze = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (EM_ALURes !== 32'd0 || Status !== 4'b0000 || EM_Dest !== 4'd0 || EM_WB_EN !== 1'b0) begin
         errors++; $display("FAIL async_rst res=%h status=%b dest=%0d wb=%b want 0", EM_ALURes, Status, EM_Dest, EM_WB_EN);
      end
      freeze = 1'b0;
      @(negedge clk) rst = 1'b1;
      drive(CMD_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 32'd40, 32'd0, 12'h002, 4'd3);
      tick();
      checks++;
      if (EM_ALURes !== 32'd42 || Status !== 4'b0000) begin
         errors++; $display("FAIL post_rst res=%h status=%b want 2a/0000", EM_ALURes, Status);
      end
      $display("async reset: res=%h status=%b", EM_ALURes, Status);
   endtask

   initial begin
      test_reset();
      test_add_imm();
      test_sub_adc_sbc();
      test_overflow();
      test_val2();
      test_logic();
      test_store();
      test_branch();
      test_freeze();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
